// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one external 8-bit multi_alu between two requesters.
// Latency: request accepted at one edge, response valid after the second edge that follows.
// Backpressure: one op in flight; response held until resp_ready, no accept while busy.
// Optional: define ALU_ARB_STATS_EN for saturating per-requester grant counters.
module alu_share_arbiter #(
    parameter int W   = 8,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [15:0]    resp_data,
    output logic           resp_flag,
    output logic           resp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_sum,
    input  logic           alu_sumflag,
    input  logic [15:0]    alu_lshift,
    input  logic           alu_less,
    input  logic           alu_equal,
    input  logic           alu_xorflag
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]     grant_cnt0,
    output logic [7:0]     grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Op and owner of the single operation in flight; operands live in alu_a/alu_b.
    typedef struct packed {
        logic [OPW-1:0] op;
        logic           id;
    } inflight_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_LSH  = OPW'(1);
    localparam logic [OPW-1:0] OP_LESS = OPW'(2);
    localparam logic [OPW-1:0] OP_EQ   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);

    state_t    state;
    logic      last_grant;
    inflight_t cur;
    logic      gnt0;
    logic      gnt1;

    // Arbitration: a lone requester wins; under contention the one not served last wins.
    always_comb begin
        gnt1       = req1_valid && (!req0_valid || !last_grant);
        gnt0       = req0_valid && !gnt1;
        req0_ready = (state == IDLE) && gnt0;
        req1_ready = (state == IDLE) && gnt1;
    end

    // Control FSM: accept in IDLE, let the ALU settle for one EXEC cycle, hold result in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_flag  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        alu_a      <= req1_ready ? req1_a : req0_a;
                        alu_b      <= req1_ready ? req1_b : req0_b;
                        cur.op     <= req1_ready ? req1_op : req0_op;
                        cur.id     <= req1_ready;
                        last_grant <= req1_ready;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_valid <= 1'b1;
                    resp_id    <= cur.id;
                    resp_data  <= '0;
                    resp_flag  <= 1'b0;
                    resp_err   <= 1'b0;
                    case (cur.op)
                        OP_ADD: begin
                            resp_data <= {{(16 - W){1'b0}}, alu_sum};
                            resp_flag <= alu_sumflag;
                        end
                        OP_LSH:  resp_data <= alu_lshift;
                        OP_LESS: resp_flag <= alu_less;
                        OP_EQ:   resp_flag <= alu_equal;
                        OP_XOR:  resp_flag <= alu_xorflag;
                        default: resp_err  <= 1'b1;
                    endcase
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Grant statistics: count accepted requests per requester, sticking at 8'hFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
            if (req1_ready && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural multi_alu on the alu_* ports.
// Inputs are driven 1ns after the rising edge and outputs sampled at that point.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        resp_valid, resp_id, resp_flag, resp_err;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic [7:0]  alu_a, alu_b, alu_sum;
    logic        alu_sumflag, alu_less, alu_equal, alu_xorflag;
    logic [15:0] alu_lshift;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]  grant_cnt0, grant_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // multi_alu behaviour: add with carry flag, shift A left by B[3:0], compares, xor parity.
    assign {alu_sumflag, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_lshift  = {8'h00, alu_a} << alu_b[3:0];
    assign alu_less    = alu_a < alu_b;
    assign alu_equal   = alu_a == alu_b;
    assign alu_xorflag = ^(alu_a ^ alu_b);

    alu_share_arbiter #(.W(8), .OPW(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_flag(resp_flag), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sum(alu_sum), .alu_sumflag(alu_sumflag), .alu_lshift(alu_lshift),
        .alu_less(alu_less), .alu_equal(alu_equal), .alu_xorflag(alu_xorflag)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        tests++; if (resp_data !== 16'h0000) begin fails++; $display("FAIL reset_resp_data got %h want 0000", resp_data); end
        tests++; if ({resp_id, resp_flag, resp_err} !== 3'b000) begin fails++; $display("FAIL reset_resp_bits got %b want 000", {resp_id, resp_flag, resp_err}); end
        tests++; if ({alu_a, alu_b} !== 16'h0000) begin fails++; $display("FAIL reset_alu_ops got %h want 0000", {alu_a, alu_b}); end
        tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    endtask

    // Single add from requester 0: 7F+01 = 80, no carry.
    task automatic test_add();
        apply_reset();
        resp_ready = 1'b1;
        req0_a = 8'h7F; req0_b = 8'h01; req0_op = 3'd0; req0_valid = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0;
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL add_exec_valid got %b want 0", resp_valid); end
        tests++; if ({alu_a, alu_b} !== 16'h7F01) begin fails++; $display("FAIL add_alu_ops got %h want 7f01", {alu_a, alu_b}); end
        step();
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL add_resp_valid got %b want 1", resp_valid); end
        tests++; if (resp_id !== 1'b0) begin fails++; $display("FAIL add_resp_id got %b want 0", resp_id); end
        tests++; if (resp_data !== 16'h0080) begin fails++; $display("FAIL add_resp_data got %h want 0080", resp_data); end
        tests++; if ({resp_flag, resp_err} !== 2'b00) begin fails++; $display("FAIL add_flag_err got %b want 00", {resp_flag, resp_err}); end
        step();
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL add_resp_drop got %b want 0", resp_valid); end
    endtask

    // Both requesters continuously valid from reset: strict alternation 0,1,0,1.
    task automatic test_round_robin();
        logic [3:0] want_id;
        want_id = 4'b1010;
        rst = 1'b1;
        req0_a = 8'h55; req0_b = 8'h55; req0_op = 3'd3; req0_valid = 1'b1;
        req1_a = 8'h55; req1_b = 8'h55; req1_op = 3'd3; req1_valid = 1'b1;
        resp_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({req1_ready, req0_ready} !== (want_id[i] ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL rr_grant%0d got r1r0=%b want id %0d", i, {req1_ready, req0_ready}, want_id[i]);
            end
            step();
            step();
            tests++;
            if ({resp_valid, resp_id, resp_flag, resp_err} !== {1'b1, want_id[i], 1'b1, 1'b0}) begin
                fails++; $display("FAIL rr_resp%0d got v/id/f/e=%b want %b", i, {resp_valid, resp_id, resp_flag, resp_err}, {1'b1, want_id[i], 2'b10});
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    // Unsupported op from requester 1.
    task automatic test_bad_op();
        apply_reset();
        resp_ready = 1'b1;
        req1_a = 8'h12; req1_b = 8'h34; req1_op = 3'd6; req1_valid = 1'b1;
        #1;
        tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL bad_ready got %b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        step();
        tests++;
        if ({resp_valid, resp_id, resp_data, resp_flag, resp_err} !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b1}) begin
            fails++; $display("FAIL bad_resp got v=%b id=%b d=%h f=%b e=%b want 1 1 0000 0 1", resp_valid, resp_id, resp_data, resp_flag, resp_err);
        end
        step();
    endtask

    // Shift result held under backpressure: 81 << 4 = 0810.
    task automatic test_backpressure();
        apply_reset();
        resp_ready = 1'b0;
        req0_a = 8'h81; req0_b = 8'h04; req0_op = 3'd1; req0_valid = 1'b1;
        req1_a = 8'h01; req1_b = 8'h02; req1_op = 3'd0;
        step();
        req1_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({resp_valid, resp_data, req0_ready, req1_ready, alu_a} !== {1'b1, 16'h0810, 2'b00, 8'h81}) begin
                fails++; $display("FAIL hold%0d got v=%b d=%h r0=%b r1=%b a=%h want 1 0810 0 0 81", i, resp_valid, resp_data, req0_ready, req1_ready, alu_a);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        tests++;
        if ({resp_valid, req0_ready, req1_ready} !== 3'b001) begin
            fails++; $display("FAIL hold_release got v=%b r0=%b r1=%b want 0 0 1", resp_valid, req0_ready, req1_ready);
        end
        tests++; if (alu_a !== 8'h81) begin fails++; $display("FAIL hold_idle_alu_a got %h want 81", alu_a); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    // Reset in EXEC clears immediately and discards the op.
    task automatic test_reset_mid_exec();
        apply_reset();
        resp_ready = 1'b1;
        req0_a = 8'hA5; req0_b = 8'h3C; req0_op = 3'd0; req0_valid = 1'b1;
        step();
        step();
        req0_valid = 1'b0;
        step();
        req1_a = 8'hC3; req1_b = 8'h0F; req1_op = 3'd2; req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        tests++; if ({alu_a, alu_b} !== 16'hC30F) begin fails++; $display("FAIL rst_pre_ops got %h want c30f", {alu_a, alu_b}); end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({resp_valid, alu_a, alu_b} !== 17'h0) begin
            fails++; $display("FAIL rst_async got v=%b a=%h b=%h want 0 00 00", resp_valid, alu_a, alu_b);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        rst = 1'b0;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL rst_first_grant got %b want 10", {req0_ready, req1_ready}); end
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        tests++; if (resp_id !== 1'b0 || resp_valid !== 1'b1) begin fails++; $display("FAIL rst_no_stale got v=%b id=%b want 1 0", resp_valid, resp_id); end
        step();
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        resp_ready = 1'b1;
        req0_a = 8'h01; req0_b = 8'h01; req0_op = 3'd0; req0_valid = 1'b1;
        repeat (9) step();
        tests++; if (grant_cnt0 !== 8'd3) begin fails++; $display("FAIL stats_cnt0_3 got %h want 03", grant_cnt0); end
        repeat (291 * 3) step();
        req0_valid = 1'b0;
        repeat (3) step();
        tests++; if (grant_cnt0 !== 8'hFF) begin fails++; $display("FAIL stats_cnt0_sat got %h want ff", grant_cnt0); end
        tests++; if (grant_cnt1 !== 8'h00) begin fails++; $display("FAIL stats_cnt1 got %h want 00", grant_cnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_bad_op();
        test_backpressure();
        test_reset_mid_exec();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
